cp0_exc_ctrl: RTL



---
 rtl/cp0_exc_ctrl.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/cp0_exc_ctrl.sv
// cp0_exc_ctrl: CP0 Status/Cause/EPC holder and exception/interrupt arbiter for the single-cycle MIPS core
//
// Redirects the PC to EXC_VECTOR on an enabled synchronous exception or a taken interrupt,
// or to EPC on eret. Cancels the writeback of an instruction that raises a synchronous exception.
// Optional feature macro: CP0_TIMER_INTR_EN adds Count(9)/Compare(11) and a timer interrupt.
//
// Ports
//   clk            core clock, rising edge
//   clrn           asynchronous active-low reset
//   pc_i / npc_i   current instruction address / fall-through next address
//   intr_i         asynchronous external interrupt level
//   is_*_i         decoded mfc0, mtc0, eret, syscall, unimplemented opcode
//   alu_ovf_i      signed overflow this cycle
//   is_branch_i    current instruction has a delay slot following it
//   in_dslot_i     current instruction sits in a delay slot
//   cp0_rd_i       CP0 register number for mfc0/mtc0
//   cp0_wdata_i    mtc0 write data
//   cp0_rdata_o    mfc0 read data (combinational, pre-edge value)
//   pc_sel_o       00 npc, 01 EPC, 10 exc_target
//   exc_target_o   exception vector
//   epc_out_o      current EPC
//   wb_cancel_o    suppress the current instruction's writeback
//   inta_o         one-cycle interrupt acknowledge
//   status_out_o   current Status
//   cause_out_o    current Cause
module cp0_exc_ctrl #(
   parameter logic [31:0] EXC_VECTOR   = 32'h0000_0008,
   parameter logic [31:0] STATUS_RESET = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        clrn,
   input  logic [31:0] pc_i,
   input  logic [31:0] npc_i,
   input  logic        intr_i,
   input  logic        is_mfc0_i,
   input  logic        is_mtc0_i,
   input  logic        is_eret_i,
   input  logic        is_syscall_i,
   input  logic        is_unimpl_i,
   input  logic        alu_ovf_i,
   input  logic        is_branch_i,
   input  logic        in_dslot_i,
   input  logic [4:0]  cp0_rd_i,
   input  logic [31:0] cp0_wdata_i,
   output logic [31:0] cp0_rdata_o,
   output logic [1:0]  pc_sel_o,
   output logic [31:0] exc_target_o,
   output logic [31:0] epc_out_o,
   output logic        wb_cancel_o,
   output logic        inta_o,
   output logic [31:0] status_out_o,
   output logic [31:0] cause_out_o
);

   localparam logic [4:0] REG_STATUS = 5'd12;
   localparam logic [4:0] REG_CAUSE  = 5'd13;
   localparam logic [4:0] REG_EPC    = 5'd14;

   logic [31:0] status_q, status_d;
   logic [31:0] epc_q, epc_d;
   logic        bd_q, bd_d;
   logic [1:0]  code_q, code_d;
   logic [1:0]  sync_q;
   logic        lvl_q;
   logic        pend_q, pend_d;
   logic        inta_q;

   logic        sys_e, uni_e, ovf_e, exc, int_take, timer_p;
   logic [1:0]  exc_code;
   logic [31:0] timer_rdata;
   logic        wr_status, wr_cause, wr_epc;

   assign sys_e    = is_syscall_i & status_q[1];
   assign uni_e    = is_unimpl_i  & status_q[2];
   assign ovf_e    = alu_ovf_i    & status_q[3];
   assign exc      = sys_e | uni_e | ovf_e;
   assign exc_code = uni_e ? 2'b10 : sys_e ? 2'b01 : 2'b11;
   // Interrupts are held off while a branch is followed by its delay slot, and during eret,
   // so EPC=npc always names a restartable instruction.
   assign int_take = (pend_q | timer_p) & status_q[0] & ~exc & ~is_branch_i & ~is_eret_i;

   assign wr_status = is_mtc0_i & (cp0_rd_i == REG_STATUS);
   assign wr_cause  = is_mtc0_i & (cp0_rd_i == REG_CAUSE);
   assign wr_epc    = is_mtc0_i & (cp0_rd_i == REG_EPC);

`ifdef CP0_TIMER_INTR_EN
   logic [31:0] count_q, count_d, compare_q, compare_d;
   logic        timer_q, timer_d;
   logic        wr_count, wr_compare;

   assign wr_count   = is_mtc0_i & (cp0_rd_i == 5'd9);
   assign wr_compare = is_mtc0_i & (cp0_rd_i == 5'd11);

   always_comb begin
      count_d   = wr_count ? cp0_wdata_i : count_q + 32'd1;
      compare_d = wr_compare ? cp0_wdata_i : compare_q;
      // A Compare write is the only way to drop the timer request.
      timer_d   = wr_compare ? 1'b0 :
                  ((count_q == compare_q) && (compare_q != 32'd0)) ? 1'b1 : timer_q;
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         count_q   <= '0;
         compare_q <= '0;
         timer_q   <= 1'b0;
      end else begin
         count_q   <= count_d;
         compare_q <= compare_d;
         timer_q   <= timer_d;
      end
   end

   assign timer_p     = timer_q;
   assign timer_rdata = (cp0_rd_i == 5'd9) ? count_q : (cp0_rd_i == 5'd11) ? compare_q : 32'd0;
`else
   assign timer_p     = 1'b0;
   assign timer_rdata = 32'd0;
`endif

   always_comb begin
      // Exception/interrupt updates take priority over an mtc0 to the same register.
      status_d = (exc | int_take) ? {status_q[27:0], 4'h0} :
                 is_eret_i        ? {4'h0, status_q[31:4]} :
                 wr_status        ? cp0_wdata_i : status_q;
      bd_d     = exc ? in_dslot_i : int_take ? 1'b0 : wr_cause ? cp0_wdata_i[31] : bd_q;
      code_d   = exc ? exc_code : int_take ? 2'b00 : wr_cause ? cp0_wdata_i[3:2] : code_q;
      epc_d    = exc      ? (in_dslot_i ? pc_i - 32'd4 : pc_i) :
                 int_take ? npc_i :
                 wr_epc   ? cp0_wdata_i : epc_q;
      // A new synced rising edge wins over the clear caused by taking the interrupt.
      pend_d   = (sync_q[1] & ~lvl_q) | (pend_q & ~int_take);
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         status_q <= STATUS_RESET;
         epc_q    <= '0;
         bd_q     <= 1'b0;
         code_q   <= 2'b00;
         sync_q   <= 2'b00;
         lvl_q    <= 1'b0;
         pend_q   <= 1'b0;
         inta_q   <= 1'b0;
      end else begin
         status_q <= status_d;
         epc_q    <= epc_d;
         bd_q     <= bd_d;
         code_q   <= code_d;
         sync_q   <= {sync_q[0], intr_i};
         lvl_q    <= sync_q[1];
         pend_q   <= pend_d;
         inta_q   <= int_take;
      end
   end

   assign cause_out_o  = {bd_q, 15'd0, timer_p, 6'd0, pend_q, 4'd0, code_q, 2'b00};
   assign status_out_o = status_q;
   assign epc_out_o    = epc_q;
   assign exc_target_o = EXC_VECTOR;
   assign inta_o       = inta_q;
   assign wb_cancel_o  = exc;
   assign pc_sel_o     = (exc | int_take) ? 2'b10 : is_eret_i ? 2'b01 : 2'b00;
   assign cp0_rdata_o  = !is_mfc0_i                ? 32'd0 :
                         (cp0_rd_i == REG_STATUS)  ? status_q :
                         (cp0_rd_i == REG_CAUSE)   ? cause_out_o :
                         (cp0_rd_i == REG_EPC)     ? epc_q : timer_rdata;

endmodule
